// File: rtl/execute_pipe_stage_if.sv
// Bundle between the decode/E register, the execute stage and the memory stage.
// The stage takes the slave view; the upstream pipeline control takes the master view.
interface execute_pipe_stage_if #(
  parameter int W = 64
);
  logic         E_valid;
  logic [3:0]   E_icode;
  logic [3:0]   E_ifun;
  logic [W-1:0] E_valA;
  logic [W-1:0] E_valB;
  logic [W-1:0] E_valC;
  logic [3:0]   E_dstE;
  logic [3:0]   E_dstM;
  logic         set_cc_inhibit;
  logic         M_stall;
  logic         M_bubble;

  logic [W-1:0] e_valE;
  logic [3:0]   e_dstE;
  logic         e_Cnd;
  logic         M_valid;
  logic [3:0]   M_icode;
  logic         M_Cnd;
  logic [W-1:0] M_valE;
  logic [W-1:0] M_valA;
  logic [3:0]   M_dstE;
  logic [3:0]   M_dstM;
  logic         ZF;
  logic         SF;
  logic         OF;

  modport master (
    output E_valid, E_icode, E_ifun, E_valA, E_valB, E_valC, E_dstE, E_dstM,
    output set_cc_inhibit, M_stall, M_bubble,
    input  e_valE, e_dstE, e_Cnd,
    input  M_valid, M_icode, M_Cnd, M_valE, M_valA, M_dstE, M_dstM,
    input  ZF, SF, OF
  );

  modport slave (
    input  E_valid, E_icode, E_ifun, E_valA, E_valB, E_valC, E_dstE, E_dstM,
    input  set_cc_inhibit, M_stall, M_bubble,
    output e_valE, e_dstE, e_Cnd,
    output M_valid, M_icode, M_Cnd, M_valE, M_valA, M_dstE, M_dstM,
    output ZF, SF, OF
  );
endinterface

// File: rtl/execute_pipe_stage.sv
// Y86-64 PIPE execute stage: ALU/valE, condition-code register, jump/cmov
// condition evaluation and the E/M pipeline register with stall/bubble control.
module execute_pipe_stage #(
  parameter int W          = 64,
  parameter int STACK_STEP = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  execute_pipe_stage_if.slave   bus
);

  typedef enum logic [3:0] {
    I_HALT   = 4'h0,
    I_NOP    = 4'h1,
    I_RRMOVQ = 4'h2,
    I_IRMOVQ = 4'h3,
    I_RMMOVQ = 4'h4,
    I_MRMOVQ = 4'h5,
    I_OPQ    = 4'h6,
    I_JXX    = 4'h7,
    I_CALL   = 4'h8,
    I_RET    = 4'h9,
    I_PUSHQ  = 4'hA,
    I_POPQ   = 4'hB
  } icode_e;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_AND = 2'd2,
    ALU_XOR = 2'd3
  } alu_fn_e;

  localparam logic [3:0]   REG_NONE = 4'hF;
  localparam logic [W-1:0] STEP     = W'(STACK_STEP);

  logic         r_zf, r_sf, r_of;
  logic         r_m_valid;
  logic [3:0]   r_m_icode;
  logic         r_m_cnd;
  logic [W-1:0] r_m_vale, r_m_vala;
  logic [3:0]   r_m_dste, r_m_dstm;

  logic [W-1:0] w_alu_a, w_alu_b, w_alu_res;
  alu_fn_e      w_alu_fn;
  logic         w_zf_n, w_sf_n, w_of_n;
  logic         w_is_opq, w_is_cond_op;
  logic         w_cond, w_cnd;
  logic [3:0]   w_dst_e;
  logic         w_set_cc;

  assign w_is_opq     = (bus.E_icode == I_OPQ);
  assign w_is_cond_op = (bus.E_icode == I_RRMOVQ) || (bus.E_icode == I_JXX);

  // Operand steering: every valE form reduces to A op B, stack steps fold into B.
  always_comb begin
    // NOTE: defaults first so every path assigns every output; prevents latch inference.
    w_alu_a  = '0;
    w_alu_b  = '0;
    w_alu_fn = ALU_ADD;
    case (bus.E_icode)
      I_OPQ: begin
        w_alu_a = bus.E_valB;
        w_alu_b = bus.E_valA;
        if (bus.E_ifun <= 4'd3) w_alu_fn = alu_fn_e'(bus.E_ifun[1:0]);
      end
      I_RRMOVQ:          w_alu_a = bus.E_valA;
      I_IRMOVQ:          w_alu_a = bus.E_valC;
      I_RMMOVQ, I_MRMOVQ: begin
        w_alu_a = bus.E_valB;
        w_alu_b = bus.E_valC;
      end
      I_CALL, I_PUSHQ: begin
        w_alu_a = bus.E_valB;
        w_alu_b = '0 - STEP;
      end
      I_RET, I_POPQ: begin
        w_alu_a = bus.E_valB;
        w_alu_b = STEP;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_alu_res = w_alu_a + w_alu_b;
    w_of_n    = 1'b0;
    case (w_alu_fn)
      ALU_ADD: begin
        w_alu_res = w_alu_a + w_alu_b;
        w_of_n    = (w_alu_a[W-1] == w_alu_b[W-1]) && (w_alu_res[W-1] != w_alu_a[W-1]);
      end
      ALU_SUB: begin
        w_alu_res = w_alu_a - w_alu_b;
        w_of_n    = (w_alu_a[W-1] != w_alu_b[W-1]) && (w_alu_res[W-1] != w_alu_a[W-1]);
      end
      ALU_AND: w_alu_res = w_alu_a & w_alu_b;
      ALU_XOR: w_alu_res = w_alu_a ^ w_alu_b;
      default: ;
    endcase
  end

  assign w_zf_n = (w_alu_res == '0);
  assign w_sf_n = w_alu_res[W-1];

  // Conditions read the registered CC, i.e. flags of the previous OPq.
  always_comb begin
    w_cond = 1'b0;
    case (bus.E_ifun)
      4'd0:    w_cond = 1'b1;
      4'd1:    w_cond = (r_sf ^ r_of) | r_zf;
      4'd2:    w_cond = r_sf ^ r_of;
      4'd3:    w_cond = r_zf;
      4'd4:    w_cond = !r_zf;
      4'd5:    w_cond = !(r_sf ^ r_of);
      4'd6:    w_cond = !((r_sf ^ r_of) | r_zf);
      default: w_cond = 1'b0;
    endcase
  end

  assign w_cnd    = bus.E_valid && w_is_cond_op && w_cond;
  assign w_dst_e  = !bus.E_valid                                 ? REG_NONE :
                    ((bus.E_icode == I_RRMOVQ) && !w_cnd)         ? REG_NONE :
                                                                    bus.E_dstE;
  assign w_set_cc = bus.E_valid && w_is_opq && !bus.set_cc_inhibit;

  // CC write ignores M_stall: a held OPq rewrites the same flags.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking for all registered state so every flop samples pre-edge values.
    if (rst) begin
      r_zf <= 1'b1;
      r_sf <= 1'b0;
      r_of <= 1'b0;
    end else if (w_set_cc) begin
      r_zf <= w_zf_n;
      r_sf <= w_sf_n;
      r_of <= w_of_n;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || bus.M_bubble) begin
      r_m_valid <= 1'b0;
      r_m_icode <= I_NOP;
      r_m_cnd   <= 1'b0;
      r_m_vale  <= '0;
      r_m_vala  <= '0;
      r_m_dste  <= REG_NONE;
      r_m_dstm  <= REG_NONE;
    end else if (!bus.M_stall) begin
      r_m_valid <= bus.E_valid;
      r_m_icode <= bus.E_icode;
      r_m_cnd   <= w_cnd;
      r_m_vale  <= w_alu_res;
      r_m_vala  <= bus.E_valA;
      r_m_dste  <= w_dst_e;
      r_m_dstm  <= bus.E_dstM;
    end
  end

  assign bus.e_valE  = w_alu_res;
  assign bus.e_dstE  = w_dst_e;
  assign bus.e_Cnd   = w_cnd;
  assign bus.M_valid = r_m_valid;
  assign bus.M_icode = r_m_icode;
  assign bus.M_Cnd   = r_m_cnd;
  assign bus.M_valE  = r_m_vale;
  assign bus.M_valA  = r_m_vala;
  assign bus.M_dstE  = r_m_dste;
  assign bus.M_dstM  = r_m_dstm;
  assign bus.ZF      = r_zf;
  assign bus.SF      = r_sf;
  assign bus.OF      = r_of;

endmodule

// File: tb/tb_execute_pipe_stage.sv
// Directed bench for execute_pipe_stage (W=64 and W=32/STACK_STEP=4 instances)
// against an arithmetic reference model, plus hand-computed literal expectations.
module tb_execute_pipe_stage;

  typedef struct packed {
    logic        valid;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [63:0] vala;
    logic [63:0] valb;
    logic [63:0] valc;
    logic [3:0]  dste;
    logic [3:0]  dstm;
    logic        inhibit;
    logic        stall;
    logic        bubble;
  } stim_t;

  typedef struct packed {
    logic        zf, sf, of;
    logic        m_valid;
    logic [3:0]  m_icode;
    logic        m_cnd;
    logic [63:0] m_vale;
    logic [63:0] m_vala;
    logic [3:0]  m_dste;
    logic [3:0]  m_dstm;
  } mstate_t;

  typedef struct packed {
    logic [63:0] vale;
    logic [3:0]  dste;
    logic        cnd;
    logic        zf, sf, of;
    logic        setcc;
  } comb_t;

  logic    clk;
  logic    rst;
  stim_t   s64, s32;
  mstate_t m64, m32;
  bit      checking;
  int      n_total;
  int      n_bad;

  execute_pipe_stage_if #(.W(64)) if64 ();
  execute_pipe_stage_if #(.W(32)) if32 ();

  execute_pipe_stage #(.W(64), .STACK_STEP(8)) dut64 (.clk(clk), .rst(rst), .bus(if64.slave));
  execute_pipe_stage #(.W(32), .STACK_STEP(4)) dut32 (.clk(clk), .rst(rst), .bus(if32.slave));

  assign if64.E_valid        = s64.valid;
  assign if64.E_icode        = s64.icode;
  assign if64.E_ifun         = s64.ifun;
  assign if64.E_valA         = s64.vala;
  assign if64.E_valB         = s64.valb;
  assign if64.E_valC         = s64.valc;
  assign if64.E_dstE         = s64.dste;
  assign if64.E_dstM         = s64.dstm;
  assign if64.set_cc_inhibit = s64.inhibit;
  assign if64.M_stall        = s64.stall;
  assign if64.M_bubble       = s64.bubble;

  assign if32.E_valid        = s32.valid;
  assign if32.E_icode        = s32.icode;
  assign if32.E_ifun         = s32.ifun;
  assign if32.E_valA         = s32.vala[31:0];
  assign if32.E_valB         = s32.valb[31:0];
  assign if32.E_valC         = s32.valc[31:0];
  assign if32.E_dstE         = s32.dste;
  assign if32.E_dstM         = s32.dstm;
  assign if32.set_cc_inhibit = s32.inhibit;
  assign if32.M_stall        = s32.stall;
  assign if32.M_bubble       = s32.bubble;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [63:0] wmask(int w);
    return (w >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
  endfunction

  function automatic logic signed [65:0] sext(logic [63:0] x, int w);
    logic signed [65:0] r;
    r = $signed({2'b00, x & wmask(w)});
    if (x[w-1]) r = r - (66'sd1 <<< w);
    return r;
  endfunction

  function automatic comb_t model_comb(stim_t s, mstate_t st, int w, int step);
    comb_t              c;
    logic [63:0]        m;
    logic signed [65:0] sa, sb, exact, smax, smin;
    logic               lt;
    m     = wmask(w);
    sa    = sext(s.valb, w);
    sb    = sext(s.vala, w);
    smax  = (66'sd1 <<< (w - 1)) - 66'sd1;
    smin  = -(66'sd1 <<< (w - 1));
    c     = '0;
    case (s.icode)
      4'h6: begin
        case (s.ifun)
          4'd1: begin exact = sa - sb; c.vale = exact[63:0] & m; c.of = (exact > smax) || (exact < smin); end
          4'd2: c.vale = s.valb & s.vala & m;
          4'd3: c.vale = (s.valb ^ s.vala) & m;
          default: begin exact = sa + sb; c.vale = exact[63:0] & m; c.of = (exact > smax) || (exact < smin); end
        endcase
      end
      4'h2:       c.vale = s.vala & m;
      4'h3:       c.vale = s.valc & m;
      4'h4, 4'h5: c.vale = (s.valb + s.valc) & m;
      4'h8, 4'hA: c.vale = (s.valb - 64'(step)) & m;
      4'h9, 4'hB: c.vale = (s.valb + 64'(step)) & m;
      default:    c.vale = 64'd0;
    endcase
    c.zf = (c.vale == 64'd0);
    c.sf = c.vale[w-1];
    lt   = st.sf ^ st.of;
    if (s.valid && (s.icode == 4'h2 || s.icode == 4'h7)) begin
      case (s.ifun)
        4'd0: c.cnd = 1'b1;
        4'd1: c.cnd = lt | st.zf;
        4'd2: c.cnd = lt;
        4'd3: c.cnd = st.zf;
        4'd4: c.cnd = !st.zf;
        4'd5: c.cnd = !lt;
        4'd6: c.cnd = !(lt | st.zf);
        default: c.cnd = 1'b0;
      endcase
    end
    if (!s.valid || (s.icode == 4'h2 && !c.cnd)) c.dste = 4'hF;
    else                                          c.dste = s.dste;
    c.setcc = s.valid && (s.icode == 4'h6) && !s.inhibit;
    return c;
  endfunction

  function automatic mstate_t model_next(mstate_t st, stim_t s, logic r, int w, int step);
    mstate_t n;
    comb_t   c;
    n = st;
    c = model_comb(s, st, w, step);
    if (r) begin
      n = '0;
      n.zf = 1'b1;
      n.m_icode = 4'h1; n.m_dste = 4'hF; n.m_dstm = 4'hF;
      return n;
    end
    if (c.setcc) begin n.zf = c.zf; n.sf = c.sf; n.of = c.of; end
    if (s.bubble) begin
      n.m_valid = 1'b0; n.m_icode = 4'h1; n.m_cnd = 1'b0;
      n.m_vale = 64'd0; n.m_vala = 64'd0; n.m_dste = 4'hF; n.m_dstm = 4'hF;
    end else if (!s.stall) begin
      n.m_valid = s.valid; n.m_icode = s.icode; n.m_cnd = c.cnd;
      n.m_vale = c.vale; n.m_vala = s.vala & wmask(w);
      n.m_dste = c.dste; n.m_dstm = s.dstm;
    end
    return n;
  endfunction

  always @(posedge clk) begin
    m64 <= model_next(m64, s64, rst, 64, 8);
    m32 <= model_next(m32, s32, rst, 32, 4);
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    comb_t c;
    if (checking) begin
      c = model_comb(s64, m64, 64, 8);
      check("e_valE64",  if64.e_valE,  c.vale);
      check("e_dstE64",  if64.e_dstE,  c.dste);
      check("e_Cnd64",   if64.e_Cnd,   c.cnd);
      check("CC64",      {if64.ZF, if64.SF, if64.OF}, {m64.zf, m64.sf, m64.of});
      check("M_ctl64",   {if64.M_valid, if64.M_icode, if64.M_Cnd, if64.M_dstE, if64.M_dstM},
                         {m64.m_valid, m64.m_icode, m64.m_cnd, m64.m_dste, m64.m_dstm});
      check("M_valE64",  if64.M_valE,  m64.m_vale);
      check("M_valA64",  if64.M_valA,  m64.m_vala);
      c = model_comb(s32, m32, 32, 4);
      check("e_valE32",  {32'd0, if32.e_valE}, c.vale);
      check("e_dstE32",  if32.e_dstE,  c.dste);
      check("e_Cnd32",   if32.e_Cnd,   c.cnd);
      check("CC32",      {if32.ZF, if32.SF, if32.OF}, {m32.zf, m32.sf, m32.of});
      check("M_ctl32",   {if32.M_valid, if32.M_icode, if32.M_Cnd, if32.M_dstE, if32.M_dstM},
                         {m32.m_valid, m32.m_icode, m32.m_cnd, m32.m_dste, m32.m_dstm});
      check("M_valE32",  {32'd0, if32.M_valE}, m32.m_vale);
      check("M_valA32",  {32'd0, if32.M_valA}, m32.m_vala);
    end
  end

  // ---------------- stimulus ----------------
  function automatic stim_t nop_s();
    stim_t s;
    s = '0;
    s.icode = 4'h1; s.dste = 4'hF; s.dstm = 4'hF;
    return s;
  endfunction

  function automatic stim_t ins(logic [3:0] icode, logic [3:0] ifun, logic [63:0] vala,
                                logic [63:0] valb, logic [63:0] valc, logic [3:0] dste);
    stim_t s;
    s = nop_s();
    s.valid = 1'b1; s.icode = icode; s.ifun = ifun;
    s.vala = vala; s.valb = valb; s.valc = valc; s.dste = dste;
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    stim_t t;
    n_total  = 0;
    n_bad    = 0;
    checking = 1'b0;
    rst = 1'b1;
    s64 = nop_s();
    s32 = nop_s();
    #2;
    tick();
    rst = 1'b0;
    checking = 1'b1;
    check("rst_ZF", if64.ZF, 1'b1);
    check("rst_SF", if64.SF, 1'b0);
    check("rst_OF", if64.OF, 1'b0);
    check("rst_M_valid", if64.M_valid, 1'b0);
    check("rst_M_icode", if64.M_icode, 4'h1);
    check("rst_M_dst",   {if64.M_dstE, if64.M_dstM}, 8'hFF);
    tick();
    check("idle_M_icode", if64.M_icode, 4'h1);

    // add overflow
    s64 = ins(4'h6, 4'h0, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0, 4'd1);
    #1;
    check("add_e_valE", if64.e_valE, 64'h8000_0000_0000_0000);
    tick();
    check("add_flags", {if64.ZF, if64.SF, if64.OF}, 3'b011);
    check("add_M_valE", if64.M_valE, 64'h8000_0000_0000_0000);

    // sub to zero, je, cmovne
    s64 = ins(4'h6, 4'h1, 64'd5, 64'd5, 64'd0, 4'd2);
    tick();
    check("sub_flags", {if64.ZF, if64.SF, if64.OF}, 3'b100);
    s64 = ins(4'h7, 4'h3, 64'd0, 64'd0, 64'h40, 4'hF);
    #1;
    check("je_e_Cnd", if64.e_Cnd, 1'b1);
    tick();
    check("je_M_Cnd", if64.M_Cnd, 1'b1);
    s64 = ins(4'h2, 4'h4, 64'h55, 64'd0, 64'd0, 4'd3);
    #1;
    check("cmovne_e_dstE", if64.e_dstE, 4'hF);
    check("cmovne_e_valE", if64.e_valE, 64'h55);
    tick();
    check("cmovne_M_dstE", if64.M_dstE, 4'hF);

    // OPq with CC inhibit
    s64 = ins(4'h6, 4'h2, 64'h0F, 64'h0F, 64'd0, 4'd4);
    s64.inhibit = 1'b1;
    tick();
    check("inh_flags", {if64.ZF, if64.SF, if64.OF}, 3'b100);
    check("inh_M_valE", if64.M_valE, 64'h0F);
    check("inh_M_valid", if64.M_valid, 1'b1);

    // irmovq and rmmovq address
    s64 = ins(4'h3, 4'h0, 64'd0, 64'd0, 64'h1234, 4'd2);
    tick();
    check("irmovq_M_valE", if64.M_valE, 64'h1234);
    s64 = ins(4'h4, 4'h0, 64'h99, 64'h10, 64'h8, 4'hF);
    tick();
    check("rmmovq_M_valE", if64.M_valE, 64'h18);
    check("rmmovq_M_valA", if64.M_valA, 64'h99);

    // stack ops, stall, stall+bubble
    s64 = ins(4'hA, 4'h0, 64'd7, 64'h100, 64'd0, 4'd4);
    tick();
    check("push_M_valE", if64.M_valE, 64'hF8);
    s64 = ins(4'hB, 4'h0, 64'd0, 64'h100, 64'd0, 4'd4);
    s64.dstm = 4'd6;
    tick();
    check("pop_M_valE", if64.M_valE, 64'h108);
    t = ins(4'h3, 4'h0, 64'd0, 64'd0, 64'h77, 4'd1);
    t.stall = 1'b1;
    s64 = t;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("stall_M_valE", if64.M_valE, 64'h108);
      check("stall_M_icode", if64.M_icode, 4'hB);
      check("stall_M_dstM", if64.M_dstM, 4'd6);
    end
    t.bubble = 1'b1;
    s64 = t;
    tick();
    check("bub_M_icode", if64.M_icode, 4'h1);
    check("bub_M_valid", if64.M_valid, 1'b0);
    check("bub_M_valE",  if64.M_valE, 64'd0);
    check("bub_M_dst",   {if64.M_dstE, if64.M_dstM}, 8'hFF);

    // CC write while stalled: 1 - 2 = -1
    s64 = ins(4'h6, 4'h1, 64'd2, 64'd1, 64'd0, 4'd3);
    s64.stall = 1'b1;
    tick();
    check("stallcc_flags", {if64.ZF, if64.SF, if64.OF}, 3'b010);
    check("stallcc_M_valid", if64.M_valid, 1'b0);

    // jl after the negative result, jXX with ifun>6
    s64 = ins(4'h7, 4'h2, 64'd0, 64'd0, 64'd0, 4'hF);
    #1;
    check("jl_e_Cnd", if64.e_Cnd, 1'b1);
    tick();
    s64 = ins(4'h7, 4'h7, 64'd0, 64'd0, 64'd0, 4'hF);
    #1;
    check("j7_e_Cnd", if64.e_Cnd, 1'b0);
    tick();

    // reset mid-stream discards pending CC write and E/M content
    s64 = ins(4'h6, 4'h3, 64'd1, 64'd0, 64'd0, 4'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst_flags", {if64.ZF, if64.SF, if64.OF}, 3'b100);
    check("mrst_M_valid", if64.M_valid, 1'b0);
    check("mrst_M_icode", if64.M_icode, 4'h1);

    // E_valid=0 forces no destination and no condition
    s64 = nop_s();
    s64.icode = 4'h2; s64.dste = 4'd5;
    #1;
    check("inv_e_dstE", if64.e_dstE, 4'hF);
    check("inv_e_Cnd",  if64.e_Cnd, 1'b0);
    tick();
    s64 = nop_s();

    // W=32, STACK_STEP=4 instance
    s32 = ins(4'h8, 4'h0, 64'd0, 64'h10, 64'h200, 4'd4);
    tick();
    check("call32_M_valE", {32'd0, if32.M_valE}, 64'hC);
    s32 = ins(4'h6, 4'h3, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'd0, 4'd1);
    tick();
    check("xor32_ZF", if32.ZF, 1'b1);
    check("xor32_OF", if32.OF, 1'b0);
    s32 = ins(4'h6, 4'h0, 64'd1, 64'h7FFF_FFFF, 64'd0, 4'd1);
    tick();
    check("add32_flags", {if32.ZF, if32.SF, if32.OF}, 3'b011);
    check("add32_M_valE", {32'd0, if32.M_valE}, 64'h8000_0000);
    s32 = nop_s();
    tick();
    tick();

    checking = 1'b0;
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/execute_pipe_stage.md
# execute_pipe_stage

Pipelined Y86-64 execute stage: computes valE, owns the registered condition-code (CC) register, evaluates jump/cmov conditions and drives the E/M pipeline register. Sits between the decode/E register and the memory stage of the PIPE processor. Succeeds the combinational SEQ execute block with:
- parametrised datapath width;
- gated CC updates;
- cmov destination cancellation;
- stall/bubble control;
- same-cycle forwarding outputs.

## Interface
Parameters:
- `W`, 64: datapath width in bits (≥ 8).
- `STACK_STEP`, 8: stack-pointer adjustment used by call/push/ret/pop.

Ports:
- `clk`  in  1  clock, all state on rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `E_valid`  in  1  E-stage holds a real instruction (0 = treat as nop).
- `E_icode`  in  4  instruction code.
- `E_ifun`  in  4  function code.
- `E_valA`, `E_valB`, `E_valC`  in  W  operands (signed).
- `E_dstE`, `E_dstM`  in  4  destination register IDs, 4'hF = none.
- `set_cc_inhibit`  in  1  memory/writeback exception present; blocks CC write.
- `M_stall`  in  1  hold E/M register.
- `M_bubble`  in  1  load nop into E/M register.
- `e_valE`  out  W  combinational valE, for forwarding.
- `e_dstE`  out  4  combinational effective dstE, for forwarding.
- `e_Cnd`  out  1  combinational condition result.
- `M_valid`  out  1  registered valid.
- `M_icode`  out  4  registered icode.
- `M_Cnd`  out  1  registered Cnd.
- `M_valE`, `M_valA`  out  W  registered values.
- `M_dstE`, `M_dstM`  out  4  registered destination IDs.
- `ZF`, `SF`, `OF`  out  1  CC register.

## Operation
- ALU operand selection (A op B), all arithmetic modulo 2^W:
  - OPq (6): A=valB, B=valA, op from ifun: 0 add, 1 sub (valB−valA), 2 and, 3 xor; ifun>3 → add.
  - rrmovq/cmovXX (2): valE = valA.
  - irmovq (3): valE = valC.
  - rmmovq (4), mrmovq (5): valE = valB + valC.
  - call (8), pushq (A): valE = valB − STACK_STEP.
  - ret (9), popq (B): valE = valB + STACK_STEP.
  - all other icodes: valE = 0.
- New flags, computed from the ALU result:
  - ZF_n = (result == 0).
  - SF_n = result[W−1].
  - OF_n, add: sign(A)==sign(B) && sign(res)!=sign(A).
  - OF_n, sub: sign(A)!=sign(B) && sign(res)!=sign(A).
  - OF_n, and/xor: 0.
- CC write: at a clock edge when `E_valid` && icode==6 && !`set_cc_inhibit` && !`rst`. The write is independent of `M_stall`.
- Condition (icode 2 or 7), from the current CC, not this instruction's flags:
  - ifun 0 always.
  - 1 le: (SF^OF)|ZF.
  - 2 l: SF^OF.
  - 3 e: ZF.
  - 4 ne: !ZF.
  - 5 ge: !(SF^OF).
  - 6 g: !((SF^OF)|ZF).
  - ifun >6 → 0.
  - For other icodes e_Cnd=0.
- e_dstE = 4'hF when icode==2 && !e_Cnd; otherwise E_dstE.
- With `E_valid`=0:
  - e_dstE = 4'hF.
  - e_Cnd = 0.
  - No CC write.
- E/M register update, priority rst > M_bubble > M_stall > load:
  - load: capture E_valid, icode, e_Cnd, e_valE, E_valA, e_dstE, E_dstM.
  - bubble: M_valid=0, M_icode=1 (nop), M_Cnd=0, M_valE=0, M_valA=0, M_dstE=M_dstM=4'hF.
  - stall: all M_* hold.

## Timing
- Reset values, one edge with `rst`=1:
  - ZF=1, SF=0, OF=0.
  - M_valid=0, M_icode=4'h1, M_Cnd=0, M_valE=0, M_valA=0, M_dstE=M_dstM=4'hF.
- Reset mid-stream discards the in-flight E/M contents and any pending CC write.
- Latency: the E-stage inputs appear on M_* one cycle later. e_* outputs are combinational, zero cycles.
- Back-to-back OPq then jXX: the jXX, one cycle later, sees CC written by the OPq.
- OPq and an inhibit in the same cycle: CC unchanged, and the OPq still flows to M.
- M_stall and M_bubble both high: bubble wins.
- A stall does not block a CC write. The stage upstream holds E inputs, and re-executing the same OPq rewrites identical flags.

## Test plan
- Reset:
  - Stimulus: assert `rst` one cycle, then release with E_valid=0.
  - Required: ZF=1, SF=0, OF=0; M_icode=1; M_dstE=M_dstM=F; M_valid=0.
- Add overflow, W=64:
  - Stimulus: OPq add, valA=1, valB=0x7FFF_FFFF_FFFF_FFFF.
  - Required: e_valE=0x8000_0000_0000_0000; next cycle SF=1, OF=1, ZF=0; M_valE matches.
- Sub to zero, then conditional ops:
  - Stimulus: OPq sub, valA=valB=5.
  - Required: ZF=1, SF=0, OF=0.
  - Then je: M_Cnd=1.
  - Then cmovne, dstE=3: e_dstE=F, M_dstE=F, e_valE=valA.
- CC inhibit:
  - Stimulus: CC={ZF1,SF0,OF0}; OPq and valA=valB=0x0F with set_cc_inhibit=1.
  - Required: CC unchanged; M_valE=0x0F.
- Stack ops and stall:
  - Stimulus: pushq with valB=0x100, then popq with valB=0x100.
  - Required: M_valE=0xF8, then 0x108.
  - Stimulus: hold M_stall=1 for 2 cycles.
  - Required: M_* frozen at 0x108.
  - Stimulus: M_stall=M_bubble=1.
  - Required: nop loaded.
- W=32 instance, STACK_STEP=4:
  - Stimulus: call, valB=0x10.
  - Required: M_valE=0xC.
  - Stimulus: OPq xor, valA=valB=0xFFFF_FFFF.
  - Required: ZF=1, OF=0.
